// File: rtl/regbank_pkg.sv
// Shared constants and SP operation encoding for the register bank with stack pointer.
package regbank_pkg;

  localparam int unsigned DataWDef   = 32;
  localparam int unsigned NregsDef   = 16;
  localparam logic [31:0] SpTopDef   = 32'hFFFF_FFFC;
  localparam logic [31:0] SpFloorDef = 32'hFFFF_FC00;
  localparam int unsigned SpStepDef  = 4;

  typedef enum logic [1:0] {
    SpHold = 2'd0,
    SpPush = 2'd1,
    SpPop  = 2'd2,
    SpLoad = 2'd3
  } sp_op_e;

endpackage

// File: rtl/sp_unit.sv
// Stack pointer register with bounded push/pop, direct load and sticky overflow/underflow flags.
module sp_unit
  import regbank_pkg::*;
#(
  parameter int unsigned DATA_W   = DataWDef,
  parameter logic [DATA_W-1:0] SP_TOP   = SpTopDef,
  parameter logic [DATA_W-1:0] SP_FLOOR = SpFloorDef,
  parameter int unsigned SP_STEP  = SpStepDef
) (
  input  logic              clk,
  input  logic              rst,
  input  sp_op_e            op,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clr_flags,
  output logic [DATA_W-1:0] sp,
  output logic [DATA_W-1:0] sp_next,
  output logic              stk_ovf,
  output logic              stk_unf
);

  logic [DATA_W-1:0] sp_q, sp_d;
  logic              ovf_q, ovf_d, unf_q, unf_d;
  logic [DATA_W:0]   sp_ext, step_ext, floor_ext, top_ext;
  logic              push_bad, pop_bad;

  // Bounds are evaluated one bit wider so a step past either end cannot wrap silently.
  always_comb begin
    sp_ext    = {1'b0, sp_q};
    step_ext  = (DATA_W+1)'(SP_STEP);
    floor_ext = {1'b0, SP_FLOOR};
    top_ext   = {1'b0, SP_TOP};
    push_bad  = sp_ext < (floor_ext + step_ext);
    pop_bad   = (sp_ext + step_ext) > top_ext;
  end

  always_comb begin
    sp_d  = sp_q;
    ovf_d = clr_flags ? 1'b0 : ovf_q;
    unf_d = clr_flags ? 1'b0 : unf_q;
    unique case (op)
      SpLoad: sp_d = wr_data;
      SpPush: begin
        if (push_bad) ovf_d = 1'b1;
        else          sp_d  = sp_q - DATA_W'(SP_STEP);
      end
      SpPop: begin
        if (pop_bad) unf_d = 1'b1;
        else         sp_d  = sp_q + DATA_W'(SP_STEP);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp_q  <= SP_TOP;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign sp      = sp_q;
  assign sp_next = sp_d;
  assign stk_ovf = ovf_q;
  assign stk_unf = unf_q;

endmodule

// File: rtl/regbank_stack.sv
// General register bank with hardwired R0, registered dual read with write bypass, and SP at NREGS.
module regbank_stack
  import regbank_pkg::*;
#(
  parameter int unsigned DATA_W   = DataWDef,
  parameter int unsigned NREGS    = NregsDef,
  parameter logic [DATA_W-1:0] SP_TOP   = SpTopDef,
  parameter logic [DATA_W-1:0] SP_FLOOR = SpFloorDef,
  parameter int unsigned SP_STEP  = SpStepDef,
  localparam int unsigned ADDR_W  = $clog2(NREGS) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              push,
  input  logic              pop,
  input  logic              clr_flags,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic [DATA_W-1:0] sp_out,
  output logic              stk_ovf,
  output logic              stk_unf
);

  localparam int unsigned IDX_W = $clog2(NREGS);
  localparam logic [ADDR_W-1:0] SP_ADDR = ADDR_W'(NREGS);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] rdata1_q, rdata2_q, sp_next;
  logic [ADDR_W-1:0] ra [2];
  logic [DATA_W-1:0] rv [2];
  logic              reg_we;
  sp_op_e            sp_op;

  assign reg_we = wr_en && (wr_addr != '0) && (wr_addr < SP_ADDR);

  always_comb begin
    if (wr_en && wr_addr == SP_ADDR) sp_op = SpLoad;
    else if (push && !pop)           sp_op = SpPush;
    else if (pop && !push)           sp_op = SpPop;
    else                             sp_op = SpHold;
  end

  sp_unit #(
    .DATA_W  (DATA_W),
    .SP_TOP  (SP_TOP),
    .SP_FLOOR(SP_FLOOR),
    .SP_STEP (SP_STEP)
  ) u_sp (
    .clk      (clk),
    .rst      (rst),
    .op       (sp_op),
    .wr_data  (wr_data),
    .clr_flags(clr_flags),
    .sp       (sp_out),
    .sp_next  (sp_next),
    .stk_ovf  (stk_ovf),
    .stk_unf  (stk_unf)
  );

  // Reads see the value being committed this edge: pending register write or next SP.
  always_comb begin
    ra[0] = rd_addr1;
    ra[1] = rd_addr2;
    for (int p = 0; p < 2; p++) begin
      rv[p] = '0;
      if (ra[p] == SP_ADDR) begin
        rv[p] = sp_next;
      end else if (ra[p] != '0 && ra[p] < SP_ADDR) begin
        rv[p] = (reg_we && wr_addr == ra[p]) ? wr_data : regs_q[ra[p][IDX_W-1:0]];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(NREGS); i++) regs_q[i] <= '0;
    end else if (reg_we) begin
      regs_q[wr_addr[IDX_W-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata1_q <= '0;
      rdata2_q <= '0;
    end else if (rd_en) begin
      rdata1_q <= rv[0];
      rdata2_q <= rv[1];
    end
  end

  assign rdata1 = rdata1_q;
  assign rdata2 = rdata2_q;

endmodule

// File: tb/tb_regbank_stack.sv
// Directed and randomized checks of regbank_stack against a behavioural register/stack model.
module tb_regbank_stack;

  localparam int unsigned NR    = 16;
  localparam logic [31:0] TOP   = 32'hFFFF_FFFC;
  localparam logic [31:0] FLOOR = 32'hFFFF_FC00;
  localparam longint      STEP  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_en, wr_en, push, pop, clr_flags;
  logic [4:0]  rd_addr1, rd_addr2, wr_addr;
  logic [31:0] wr_data;
  logic [31:0] rdata1, rdata2, sp_out;
  logic        stk_ovf, stk_unf;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m_regs [NR];
  logic [31:0] m_sp, m_rd1, m_rd2;
  logic        m_ovf, m_unf;

  always #5 clk = ~clk;

  regbank_stack dut (
    .clk      (clk),
    .rst      (rst),
    .rd_en    (rd_en),
    .rd_addr1 (rd_addr1),
    .rd_addr2 (rd_addr2),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .push     (push),
    .pop      (pop),
    .clr_flags(clr_flags),
    .rdata1   (rdata1),
    .rdata2   (rdata2),
    .sp_out   (sp_out),
    .stk_ovf  (stk_ovf),
    .stk_unf  (stk_unf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    rd_en = 0; wr_en = 0; push = 0; pop = 0; clr_flags = 0;
    rd_addr1 = '0; rd_addr2 = '0; wr_addr = '0; wr_data = '0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(NR); i++) m_regs[i] = '0;
    m_sp = TOP; m_rd1 = '0; m_rd2 = '0; m_ovf = 0; m_unf = 0;
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] a, input logic [31:0] nsp);
    if (a == 0) return '0;
    if (int'(a) < int'(NR)) return (wr_en && wr_addr == a) ? wr_data : m_regs[a[3:0]];
    if (int'(a) == int'(NR)) return nsp;
    return '0;
  endfunction

  task automatic check_all(input string tag);
    check({tag, "_rd1"}, rdata1, m_rd1);
    check({tag, "_rd2"}, rdata2, m_rd2);
    check({tag, "_sp"}, sp_out, m_sp);
    check({tag, "_ovf"}, {31'd0, stk_ovf}, {31'd0, m_ovf});
    check({tag, "_unf"}, {31'd0, stk_unf}, {31'd0, m_unf});
  endtask

  // Predict one clock edge from the current inputs, then compare just after it.
  task automatic tick(input string tag);
    logic [31:0] nsp;
    logic        ev_o, ev_u;
    nsp = m_sp; ev_o = 0; ev_u = 0;
    if (wr_en && int'(wr_addr) == int'(NR)) nsp = wr_data;
    else if (push && !pop) begin
      if (longint'(m_sp) - STEP < longint'(FLOOR)) ev_o = 1;
      else nsp = m_sp - 32'(STEP);
    end else if (pop && !push) begin
      if (longint'(m_sp) + STEP > longint'(TOP)) ev_u = 1;
      else nsp = m_sp + 32'(STEP);
    end
    if (rd_en) begin
      m_rd1 = m_read(rd_addr1, nsp);
      m_rd2 = m_read(rd_addr2, nsp);
    end
    if (wr_en && wr_addr != 0 && int'(wr_addr) < int'(NR)) m_regs[wr_addr[3:0]] = wr_data;
    m_ovf = ev_o ? 1'b1 : (clr_flags ? 1'b0 : m_ovf);
    m_unf = ev_u ? 1'b1 : (clr_flags ? 1'b0 : m_unf);
    m_sp  = nsp;
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic sp_write(input logic [31:0] v);
    idle(); wr_en = 1; wr_addr = 5'd16; wr_data = v;
    tick("spwr");
  endtask

  initial begin
    idle();
    rst = 0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rst = 1;

    // Read R0 and SP right after reset.
    rd_en = 1; rd_addr1 = 5'd0; rd_addr2 = 5'd16;
    tick("rd0sp");
    check("rd0sp_c1", rdata1, 32'h0);
    check("rd0sp_c2", rdata2, 32'hFFFF_FFFC);

    // Write with same-cycle read bypass, then R0 write ignored.
    idle(); rd_en = 1; rd_addr1 = 5'd3; wr_en = 1; wr_addr = 5'd3; wr_data = 32'h1234;
    tick("byp");
    check("byp_c", rdata1, 32'h1234);
    idle(); rd_en = 1; wr_en = 1; wr_addr = 5'd0; wr_data = 32'h5;
    tick("wr0");
    idle(); rd_en = 1; rd_addr2 = 5'd0; rd_addr1 = 5'd3;
    tick("rd0");
    check("rd0_c", rdata2, 32'h0);

    // Push x3, pop, push+pop.
    idle(); push = 1;
    repeat (3) tick("push");
    check("push3_c", sp_out, 32'hFFFF_FFF0);
    idle(); pop = 1;
    tick("pop");
    check("pop_c", sp_out, 32'hFFFF_FFF4);
    idle(); push = 1; pop = 1;
    tick("pushpop");
    check("pushpop_c", sp_out, 32'hFFFF_FFF4);

    // Underflow at top, sticky until cleared.
    sp_write(TOP);
    idle(); pop = 1;
    tick("unf");
    check("unf_c", {31'd0, stk_unf}, 32'd1);
    idle();
    tick("unf_hold");
    check("unf_hold_c", {31'd0, stk_unf}, 32'd1);
    clr_flags = 1;
    tick("unf_clr");
    check("unf_clr_c", {31'd0, stk_unf}, 32'd0);

    // Overflow at floor; event beats same-cycle clear.
    sp_write(FLOOR);
    idle(); push = 1;
    tick("ovf");
    check("ovf_c", {31'd0, stk_ovf}, 32'd1);
    check("ovf_sp_c", sp_out, 32'hFFFF_FC00);
    clr_flags = 1;
    tick("ovf_clr_win");
    check("ovf_win_c", {31'd0, stk_ovf}, 32'd1);
    idle(); clr_flags = 1;
    tick("ovf_clr");

    // Reset arriving between edges discards a queued write.
    @(negedge clk);
    idle(); wr_en = 1; wr_addr = 5'd5; wr_data = 32'h7; push = 1;
    #2;
    rst = 0;
    model_reset();
    #1;
    check_all("rst_async");
    @(posedge clk);
    #1;
    check_all("rst_hold");
    @(negedge clk);
    idle();
    rst = 1;
    rd_en = 1; rd_addr1 = 5'd5; rd_addr2 = 5'd16;
    tick("post_rst");
    check("post_rst_r5", rdata1, 32'h0);
    check("post_rst_sp", rdata2, 32'hFFFF_FFFC);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      int unsigned k;
      rd_en     = ($urandom_range(0, 3) != 0);
      rd_addr1  = 5'($urandom_range(0, 31));
      rd_addr2  = ($urandom_range(0, 3) == 0) ? 5'd16 : 5'($urandom_range(0, 20));
      wr_en     = ($urandom_range(0, 1) == 1);
      wr_addr   = ($urandom_range(0, 2) == 0) ? rd_addr1 : 5'($urandom_range(0, 17));
      wr_data   = $urandom;
      if (wr_en && wr_addr == 5'd16) begin
        k = $urandom_range(0, 5);
        case (k)
          0: wr_data = TOP;
          1: wr_data = TOP - 32'd4;
          2: wr_data = FLOOR;
          3: wr_data = FLOOR + 32'd4;
          4: wr_data = 32'd2;
          default: ;
        endcase
      end
      push      = ($urandom_range(0, 2) == 0);
      pop       = ($urandom_range(0, 2) == 0);
      clr_flags = ($urandom_range(0, 7) == 0);
      tick("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
